adder_driver: RTL and testbench

ADDER_DRIVER -- requirements
Module: adder_driver

---
 rtl/adder_driver_pkg.sv | 21 ++
 rtl/adder_driver_timer.sv | 43 ++++
 rtl/adder_driver.sv | 114 +++++++++++
 tb/tb_adder_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_driver_pkg.sv
// Shared types and default parameters for the adder self-test driver.
package adder_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int DEF_WIDTH   = 1;
    localparam int DEF_TIMEOUT = 4;
    localparam int DEF_SETTLE  = 0;

    // Bits needed to count up to the last WAIT cycle (SETTLE+TIMEOUT-1).
    function automatic int timer_bits(input int settle, input int timeout);
        return (settle + timeout > 1) ? $clog2(settle + timeout) : 1;
    endfunction

endpackage

// File: rtl/adder_driver_timer.sv
// WAIT-state timer: arms the answer comparison once the settle window has
// passed and flags the last cycle in which a match is still accepted.
module adder_driver_timer
    import adder_driver_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic armed,
    output logic expired
);

    localparam int TW = timer_bits(SETTLE, TIMEOUT);
    localparam logic [TW-1:0] LAST_V = TW'(SETTLE + TIMEOUT - 1);

    logic [TW-1:0] count;

    // Cycle counter, restarted for every vector and stepped while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + TW'(1);
        end
    end

    // With no settle window the comparison is live from the first WAIT cycle.
    if (SETTLE == 0) begin : g_no_settle
        assign armed = 1'b1;
    end else begin : g_settle
        localparam logic [TW-1:0] SETTLE_V = TW'(SETTLE);
        assign armed = (count >= SETTLE_V);
    end

    assign expired = (count == LAST_V);

endmodule

// File: rtl/adder_driver.sv
// Exhaustive adder test driver: walks every operand pair in ascending order,
// waits for the responder's answer and tallies passes and failures.
module adder_driver
    import adder_driver_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   operand1,
    output logic [WIDTH-1:0]   operand2,
    input  logic [WIDTH:0]     ans,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   pass_cnt,
    output logic [2*WIDTH:0]   fail_cnt,
    output logic               first_fail_valid,
    output logic [2*WIDTH-1:0] first_fail_idx,
    output logic               all_pass
);

    localparam int IW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST_IDX = '1;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WIDTH:0]  expect_sum;
    logic            armed;
    logic            expired;
    logic            match;

    assign expect_sum = {1'b0, operand1} + {1'b0, operand2};
    assign match      = armed && (ans == expect_sum);

    adder_driver_timer #(
        .TIMEOUT(TIMEOUT),
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_DRIVE),
        .advance(state == S_WAIT && !match && !expired),
        .armed  (armed),
        .expired(expired)
    );

    // Run sequencer; all status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            idx              <= '0;
            operand1         <= '0;
            operand2         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            all_pass         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx              <= '0;
                        pass_cnt         <= '0;
                        fail_cnt         <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                        done             <= 1'b0;
                        all_pass         <= 1'b0;
                        busy             <= 1'b1;
                        state            <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    operand1 <= idx[IW-1:WIDTH];
                    operand2 <= idx[WIDTH-1:0];
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (match) begin
                        pass_cnt <= pass_cnt + 1'b1;
                        state    <= S_NEXT;
                    end else if (expired) begin
                        fail_cnt <= fail_cnt + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_idx <= idx;
                        end
                        first_fail_valid <= 1'b1;
                        state            <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        // fail_cnt is final here: it only moves in WAIT.
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        all_pass <= (fail_cnt == '0);
                        state    <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_driver.sv
// Self-checking bench for adder_driver: table-driven runs on a WIDTH=1
// instance, delayed-responder instances, and randomized WIDTH=2 runs
// checked against a per-vector reference model.
module tb_adder_driver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- instance A: WIDTH=1, TIMEOUT=4, SETTLE=0 ----------------
    logic       a_start;
    logic [0:0] a_op1, a_op2;
    logic [1:0] a_ans;
    logic       a_busy, a_done, a_ffv, a_all;
    logic [2:0] a_pass, a_fail;
    logic [1:0] a_ffi;
    int         a_mode;  // 0 = correct adder, 1 = stuck at zero

    assign a_ans = (a_mode == 0) ? ({1'b0, a_op1} + {1'b0, a_op2}) : 2'd0;

    adder_driver #(.WIDTH(1), .TIMEOUT(4), .SETTLE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .operand1(a_op1), .operand2(a_op2),
        .ans(a_ans), .busy(a_busy), .done(a_done), .pass_cnt(a_pass), .fail_cnt(a_fail),
        .first_fail_valid(a_ffv), .first_fail_idx(a_ffi), .all_pass(a_all));

    // ------- instances D/E: responder with a 2-cycle registered delay -------
    logic       d_start, e_start;
    logic [0:0] d_op1, d_op2, e_op1, e_op2;
    logic [1:0] d_p1, d_p2, e_p1, e_p2;
    logic       d_busy, d_done, d_ffv, d_all, e_busy, e_done, e_ffv, e_all;
    logic [2:0] d_pass, d_fail, e_pass, e_fail;
    logic [1:0] d_ffi, e_ffi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_p1 <= '0; d_p2 <= '0; e_p1 <= '0; e_p2 <= '0;
        end else begin
            d_p1 <= {1'b0, d_op1} + {1'b0, d_op2};
            d_p2 <= d_p1;
            e_p1 <= {1'b0, e_op1} + {1'b0, e_op2};
            e_p2 <= e_p1;
        end
    end

    adder_driver #(.WIDTH(1), .TIMEOUT(4), .SETTLE(2)) u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .operand1(d_op1), .operand2(d_op2),
        .ans(d_p2), .busy(d_busy), .done(d_done), .pass_cnt(d_pass), .fail_cnt(d_fail),
        .first_fail_valid(d_ffv), .first_fail_idx(d_ffi), .all_pass(d_all));

    // No settle window and a single-cycle timeout, so stale answers are judged.
    adder_driver #(.WIDTH(1), .TIMEOUT(1), .SETTLE(0)) u_e (
        .clk(clk), .rst_n(rst_n), .start(e_start), .operand1(e_op1), .operand2(e_op2),
        .ans(e_p2), .busy(e_busy), .done(e_done), .pass_cnt(e_pass), .fail_cnt(e_fail),
        .first_fail_valid(e_ffv), .first_fail_idx(e_ffi), .all_pass(e_all));

    // ------------- instance R: WIDTH=2, TIMEOUT=3, random responder -------------
    localparam int R_TO = 3;
    logic       r_start;
    logic [1:0] r_op1, r_op2;
    logic [2:0] r_ans;
    logic       r_busy, r_done, r_ffv, r_all;
    logic [4:0] r_pass, r_fail;
    logic [3:0] r_ffi;
    int         r_delay [16];
    bit         r_good  [16];
    int         r_cnt;
    logic [3:0] r_prev;

    // Cycles since the current operand pair appeared (0 in the first WAIT cycle).
    always @(negedge clk) begin
        if (!r_busy)                     r_cnt <= -2;
        else if ({r_op1, r_op2} != r_prev) r_cnt <= 0;
        else                             r_cnt <= r_cnt + 1;
        r_prev <= {r_op1, r_op2};
    end

    always_comb begin
        r_ans = {1'b0, r_op1} + {1'b0, r_op2};
        if (!(r_good[{r_op1, r_op2}] && r_cnt >= r_delay[{r_op1, r_op2}]))
            r_ans = r_ans + 3'd1;
    end

    adder_driver #(.WIDTH(2), .TIMEOUT(R_TO), .SETTLE(0)) u_r (
        .clk(clk), .rst_n(rst_n), .start(r_start), .operand1(r_op1), .operand2(r_op2),
        .ans(r_ans), .busy(r_busy), .done(r_done), .pass_cnt(r_pass), .fail_cnt(r_fail),
        .first_fail_valid(r_ffv), .first_fail_idx(r_ffi), .all_pass(r_all));

    // ---------------------------- table for instance A ----------------------------
    typedef struct {
        int mode;
        bit pulse;   // extra start pulse mid-run
        int pass;
        int fail;
        bit ffv;
        int ffi;
        bit allp;
        int cyc;     // cycles from accepting edge to done
    } row_t;

    row_t rows [4];

    task automatic run_a(input row_t r, input string tag);
        int cyc;
        a_mode = r.mode;
        @(negedge clk) a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check({tag, "_busy_on_accept"}, a_busy, 1);
        check({tag, "_done_cleared"}, a_done, 0);
        cyc = 0;
        while (!a_done && cyc < 200) begin
            @(posedge clk); #1 cyc++;
            if (r.mode == 0 && cyc % 3 == 1)
                check({tag, "_operands"}, {a_op1, a_op2}, (cyc - 1) / 3);
            if (r.pulse && cyc == 5) a_start = 1'b1;
            if (r.pulse && cyc == 6) a_start = 1'b0;
        end
        check({tag, "_done"}, a_done, 1);
        check({tag, "_cycles"}, cyc, r.cyc);
        check({tag, "_pass"}, a_pass, r.pass);
        check({tag, "_fail"}, a_fail, r.fail);
        check({tag, "_ffv"}, a_ffv, r.ffv);
        check({tag, "_ffi"}, a_ffi, r.ffi);
        check({tag, "_all_pass"}, a_all, r.allp);
        check({tag, "_busy_off"}, a_busy, 0);
        repeat (3) @(posedge clk);
        #1 check({tag, "_done_held"}, a_done, 1);
        check({tag, "_operands_held"}, {a_op1, a_op2}, 3);
    endtask

    // Reference model for instance R: a vector passes if the responder is
    // right within the timeout; WAIT lasts delay+1 on a pass, TIMEOUT on a fail.
    task automatic run_r(input string tag);
        int e_pass = 0, e_fail = 0, e_ffi = 0, e_cyc = 0, cyc;
        bit e_ffv = 0;
        for (int i = 0; i < 16; i++) begin
            if (r_good[i] && r_delay[i] <= R_TO - 1) begin
                e_pass++;
                e_cyc += 3 + r_delay[i];
            end else begin
                e_fail++;
                e_cyc += 2 + R_TO;
                if (!e_ffv) e_ffi = i;
                e_ffv = 1;
            end
        end
        @(negedge clk) r_start = 1'b1;
        @(posedge clk); #1 r_start = 1'b0;
        cyc = 0;
        while (!r_done && cyc < 500) begin
            @(posedge clk); #1 cyc++;
        end
        check({tag, "_done"}, r_done, 1);
        check({tag, "_cycles"}, cyc, e_cyc);
        check({tag, "_pass"}, r_pass, e_pass);
        check({tag, "_fail"}, r_fail, e_fail);
        check({tag, "_ffv"}, r_ffv, e_ffv);
        if (e_ffv) check({tag, "_ffi"}, r_ffi, e_ffi);
        check({tag, "_all_pass"}, r_all, e_fail == 0);
    endtask

    task automatic run_de(input bit use_d, output int cyc);
        @(negedge clk);
        if (use_d) d_start = 1'b1; else e_start = 1'b1;
        @(posedge clk); #1 d_start = 1'b0; e_start = 1'b0;
        cyc = 0;
        while (!(use_d ? d_done : e_done) && cyc < 200) begin
            @(posedge clk); #1 cyc++;
        end
    endtask

    initial begin
        int cyc;
        bit saw_done;
        rows[0] = '{0, 1'b0, 4, 0, 1'b0, 0, 1'b1, 12};
        rows[1] = '{0, 1'b1, 4, 0, 1'b0, 0, 1'b1, 12};
        rows[2] = '{1, 1'b0, 1, 3, 1'b1, 1, 1'b0, 21};
        rows[3] = '{0, 1'b0, 4, 0, 1'b0, 0, 1'b1, 12};

        rst_n = 1'b0;
        a_start = 0; d_start = 0; e_start = 0; r_start = 0;
        a_mode = 0;
        for (int i = 0; i < 16; i++) begin r_delay[i] = 0; r_good[i] = 1; end

        #12;
        check("reset_outputs_a", {a_op1, a_op2, a_busy, a_done, a_pass, a_fail, a_ffv, a_ffi, a_all}, 0);
        check("reset_outputs_r", {r_op1, r_op2, r_busy, r_done, r_pass, r_fail, r_ffv, r_ffi, r_all}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_no_done", a_done, 0);

        for (int i = 0; i < 4; i++) run_a(rows[i], $sformatf("row%0d", i));

        // Reset during vector 2 WAIT aborts the run.
        a_mode = 0;
        @(negedge clk) a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 0;
        while (cyc < 7) begin @(posedge clk); #1 cyc++; end
        check("pre_reset_vector2", {a_op1, a_op2}, 2);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {a_op1, a_op2, a_busy, a_done, a_pass, a_fail, a_ffv, a_ffi, a_all}, 0);
        @(negedge clk) rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin @(posedge clk); #1 if (a_done || a_busy) saw_done = 1; end
        check("no_done_after_abort", saw_done, 0);
        run_a(rows[0], "post_reset");

        // Delayed responder with settle window: all pass, 5 cycles per vector.
        run_de(1'b1, cyc);
        check("settle_done", d_done, 1);
        check("settle_cycles", cyc, 20);
        check("settle_pass", d_pass, 4);
        check("settle_fail", d_fail, 0);
        check("settle_all_pass", d_all, 1);

        // Same responder without settle: stale answers get judged.
        run_de(1'b0, cyc);
        check("nosettle_done", e_done, 1);
        check("nosettle_has_fail", e_fail != 0, 1);
        check("nosettle_total", e_pass + e_fail, 4);
        check("nosettle_all_pass", e_all, 0);

        // WIDTH=2 correct immediate adder: 16 vectors in 48 cycles.
        run_r("w2_correct");

        // Randomized responder plans.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) begin
                r_delay[i] = $urandom_range(0, R_TO + 1);
                r_good[i]  = ($urandom_range(0, 7) != 0);
            end
            run_r($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
